// File: rtl/servo_frame_scheduler.sv
// Four-channel hobby-servo frame scheduler sharing one pulse timer.
// Angles are double-buffered and swapped in only at the frame boundary.
module servo_frame_scheduler #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int FRAME_US  = 20000,
    parameter int MIN_US    = 1000,
    parameter int ANGLE_MAX = 180
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       enable,
    input  logic       wr_valid,
    input  logic [1:0] wr_ch,
    input  logic [7:0] wr_angle,
    output logic       wr_ready,
    output logic [3:0] servo_pwm,
    output logic [1:0] active_ch,
    output logic       frame_start,
    output logic       busy
);

    localparam int TICK_DIV   = CLK_HZ / 1_000_000;
    localparam int FRAME_CLKS = FRAME_US * TICK_DIV;
    localparam int K          = (1000 * 256) / ANGLE_MAX;
    localparam int DW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW         = $clog2(FRAME_CLKS);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        PULSE,
        WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ch_q, ch_d;
    logic [DW-1:0]   div_q, div_d;
    logic [15:0]     us_q, us_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [3:0][7:0] pend_q, pend_d;
    logic [3:0][7:0] act_q, act_d;

    logic [7:0]  wr_clamp;
    logic [18:0] prod;
    logic [15:0] width_us;
    logic        tick;
    logic        last_us;
    logic        last_frame;

    assign wr_clamp   = (wr_angle > 8'(ANGLE_MAX)) ? 8'(ANGLE_MAX) : wr_angle;
    assign prod       = 19'(act_q[ch_q]) * 19'(K);
    assign width_us   = 16'(MIN_US) + 16'(prod >> 8);
    assign tick       = (div_q == DW'(TICK_DIV - 1));
    assign last_us    = (us_q == width_us - 16'd1);
    assign last_frame = (frame_q == FW'(FRAME_CLKS - 2));

    // Angle buffers: writes land in pending, COMMIT copies pending to active.
    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        if (wr_valid && wr_ready) begin
            pend_d[wr_ch] = wr_clamp;
        end
        if (state_q == COMMIT) begin
            act_d = pend_q;
        end
    end

    // Next-state logic: frame sequencing and the shared µs pulse timer.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        div_d   = div_q;
        us_d    = us_q;
        frame_d = frame_q;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = PULSE;
                ch_d    = 2'd0;
                div_d   = '0;
                us_d    = '0;
                frame_d = '0;
            end
            PULSE: begin
                frame_d = frame_q + FW'(1);
                if (tick) begin
                    div_d = '0;
                    if (last_us) begin
                        us_d = '0;
                        if (ch_q == 2'd3) begin
                            state_d = WAIT;
                        end else begin
                            ch_d = ch_q + 2'd1;
                        end
                    end else begin
                        us_d = us_q + 16'd1;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            WAIT: begin
                frame_d = frame_q + FW'(1);
                if (last_frame) begin
                    state_d = enable ? COMMIT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and buffer registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            div_q   <= '0;
            us_q    <= '0;
            frame_q <= '0;
            pend_q  <= {4{8'd90}};
            act_q   <= {4{8'd90}};
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            div_q   <= div_d;
            us_q    <= us_d;
            frame_q <= frame_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        servo_pwm   = '0;
        active_ch   = 2'd0;
        frame_start = (state_q == COMMIT);
        busy        = (state_q != IDLE);
        wr_ready    = (state_q != COMMIT);
        if (state_q == PULSE) begin
            servo_pwm[ch_q] = 1'b1;
            active_ch       = ch_q;
        end
    end

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Bench for servo_frame_scheduler: frame-position reference model,
// per-cycle output comparison plus directed pulse-width checks.
module tb_servo_frame_scheduler;

    localparam int FRAME = 20000;
    localparam int MIN   = 1000;
    localparam int AMAX  = 180;
    localparam int K     = (1000 * 256) / AMAX;

    logic       CLK;
    logic       nRST;
    logic       enable;
    logic       wr_valid;
    logic [1:0] wr_ch;
    logic [7:0] wr_angle;
    logic       wr_ready;
    logic [3:0] servo_pwm;
    logic [1:0] active_ch;
    logic       frame_start;
    logic       busy;

    servo_frame_scheduler #(
        .CLK_HZ   (1_000_000),
        .FRAME_US (FRAME),
        .MIN_US   (MIN),
        .ANGLE_MAX(AMAX)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_ch      (wr_ch),
        .wr_angle   (wr_angle),
        .wr_ready   (wr_ready),
        .servo_pwm  (servo_pwm),
        .active_ch  (active_ch),
        .frame_start(frame_start),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    bit m_idle;
    bit m_commit;
    int m_p;
    int m_pend[4];
    int m_act[4];

    int       run_len[4];
    int       last_w[4];
    logic [3:0] prev_pwm = '0;
    bit       prev_busy = 1'b0;
    int       t_rise0 = -1;
    int       t_fall = -1;
    int       t_en;
    int       fs_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    function automatic int wfn(input int a);
        return MIN + ((a * K) >> 8);
    endfunction

    // Expected {wr_ready, busy, frame_start, active_ch, servo_pwm}.
    function automatic logic [8:0] m_outs();
        logic [3:0] pwm = '0;
        logic [1:0] ach = '0;
        int cum = 0;
        if (m_idle) return 9'b1_0_0_00_0000;
        if (m_commit) return 9'b0_1_1_00_0000;
        for (int n = 0; n < 4; n++) begin
            int w;
            w = wfn(m_act[n]);
            if (m_p >= cum && m_p < cum + w) begin
                pwm[n] = 1'b1;
                ach = 2'(n);
            end
            cum += w;
        end
        return {1'b1, 1'b1, 1'b0, ach, pwm};
    endfunction

    task automatic model_reset();
        m_idle = 1'b1;
        m_commit = 1'b0;
        m_p = 0;
        for (int n = 0; n < 4; n++) begin
            m_pend[n] = 90;
            m_act[n] = 90;
        end
    endtask

    task automatic mstep(input bit en, input bit wv, input int wc, input int wa);
        if (wv && !m_commit) m_pend[wc] = (wa > AMAX) ? AMAX : wa;
        if (m_idle) begin
            if (en) begin
                m_idle = 1'b0;
                m_commit = 1'b1;
            end
        end else if (m_commit) begin
            for (int n = 0; n < 4; n++) m_act[n] = m_pend[n];
            m_commit = 1'b0;
            m_p = 0;
        end else if (m_p == FRAME - 2) begin
            m_p = 0;
            if (en) m_commit = 1'b1;
            else m_idle = 1'b1;
        end else begin
            m_p++;
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        chk("outs", int'({wr_ready, busy, frame_start, active_ch, servo_pwm}),
            int'(m_outs()));
        for (int n = 0; n < 4; n++) begin
            if (servo_pwm[n]) begin
                run_len[n]++;
            end else if (run_len[n] > 0) begin
                last_w[n] = run_len[n];
                run_len[n] = 0;
            end
        end
        if (servo_pwm[0] && !prev_pwm[0] && t_rise0 < 0) t_rise0 = cyc_n;
        if (frame_start) fs_q.push_back(cyc_n);
        if (prev_busy && !busy) t_fall = cyc_n;
        prev_pwm = servo_pwm;
        prev_busy = busy;
        if (!nRST) model_reset();
        else mstep(enable, wr_valid, int'(wr_ch), int'(wr_angle));
        cyc_n++;
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int ch, input int a);
        wr_valid = 1'b1;
        wr_ch = 2'(ch);
        wr_angle = 8'(a);
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic run_to(input int tgt);
        int i = 0;
        while (!(!m_idle && !m_commit && m_p == tgt) && i < 25000) begin
            cyc();
            i++;
        end
        if (i >= 25000) chk("run_to_timeout", m_p, tgt);
    endtask

    task automatic run_commit();
        int i = 0;
        while (!m_commit && i < 25000) begin
            cyc();
            i++;
        end
        if (i >= 25000) chk("commit_timeout", 0, 1);
    endtask

    task automatic run_idle();
        int i = 0;
        while (!m_idle && i < 25000) begin
            cyc();
            i++;
        end
        if (i >= 25000) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        nRST = 1'b0;
        enable = 1'b0;
        wr_valid = 1'b0;
        wr_ch = 2'd0;
        wr_angle = 8'd0;
        for (int n = 0; n < 4; n++) begin
            run_len[n] = 0;
            last_w[n] = 0;
        end
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        cyc();
        nRST = 1'b1;
        repeat (3) cyc();

        // Frame 1: default angles, no writes before enable.
        enable = 1'b1;
        t_en = cyc_n;
        run_to(3000);
        chk("rise_latency", t_rise0 - t_en, 2);
        wr(2, 0);
        run_to(6000);
        for (int n = 0; n < 4; n++) chk("f1_width", last_w[n], 1499);

        // Random writes to ch0/ch1 during the WAIT gap.
        for (int k = 0; k < 3; k++) begin
            run_to(6000 + k * 4000 + $urandom_range(0, 3000));
            wr($urandom_range(0, 1), $urandom_range(0, 255));
        end

        // Write presented in the COMMIT cycle stalls one cycle.
        run_commit();
        chk("stall_rdy", wr_ready, 0);
        wr_valid = 1'b1;
        wr_ch = 2'd3;
        wr_angle = 8'd45;
        cyc();
        chk("accept_rdy", wr_ready, 1);
        cyc();
        wr_valid = 1'b0;
        chk("fs_count", fs_q.size(), 2);
        chk("period", fs_q[1] - fs_q[0], FRAME);

        // Frame 2: ch2 takes the mid-pulse write, ch3 not yet.
        run_to(8000);
        chk("f2_w0", last_w[0], wfn(m_act[0]));
        chk("f2_w1", last_w[1], wfn(m_act[1]));
        chk("f2_w2", last_w[2], 1000);
        chk("f2_w3", last_w[3], 1499);

        // Frame 3: drop enable during ch1, frame completes then IDLE.
        run_commit();
        cyc();
        run_to(wfn(m_act[0]) + 3);
        enable = 1'b0;
        run_idle();
        cyc();
        chk("f3_w1", last_w[1], wfn(m_act[1]));
        chk("f3_w2", last_w[2], 1000);
        chk("f3_w3", last_w[3], 1249);
        chk("idle_at", t_fall - fs_q[2], FRAME);
        repeat ($urandom_range(5, 20)) cyc();
        chk("idle_busy", busy, 0);

        // Writes while IDLE including an out-of-range angle.
        wr(0, 0);
        wr(1, 180);
        wr(2, 200);
        wr(3, 45);
        enable = 1'b1;
        run_to(4998 + $urandom_range(100, 1000));
        chk("f4_w0", last_w[0], 1000);
        chk("f4_w1", last_w[1], 1999);
        chk("f4_w2", last_w[2], 1999);
        chk("f4_ch3_on", servo_pwm, 4'b1000);

        // Asynchronous reset in the middle of ch3's pulse.
        nRST = 1'b0;
        enable = 1'b0;
        #1;
        chk("async_pwm", servo_pwm, 0);
        chk("async_busy", busy, 0);
        model_reset();
        cyc();
        nRST = 1'b1;
        repeat (3) cyc();
        enable = 1'b1;
        repeat (1600) cyc();
        chk("post_rst_w0", last_w[0], 1499);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
